register_write_arbiter: RTL and testbench

//  Shares a bank of NREG 16-bit load-enabled registers (ports out/load/d/clk) between NREQ write requesters.

---
 rtl/register_write_arbiter_pkg.sv | 16 +
 rtl/register_write_arbiter_rr_pick.sv | 31 +++
 rtl/register_write_arbiter.sv | 116 +++++++++++
 tb/tb_register_write_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_write_arbiter_pkg.sv
// Shared constants for the register write arbiter: FSM state codes, default widths, one-hot decode.
package register_write_arbiter_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 3;

  // Wide decode; callers size-cast the result down to their vector width.
  function automatic logic [255:0] onehot(input logic [7:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/register_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PW:0]       sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: NREQ];
    any = |rot;
    win = '0;
    sum = '0;
    // Scan downward so the lowest rotated offset is the last one written.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (PW+1)'(k);
        win = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter driving a shared register bank; one write per IDLE/WRITE pair.
// Optional macro ARB_LOCK_EN adds a lock input that keeps the grant pointer on the winner.
module register_write_arbiter
  import register_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NREG = 8,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREG-1:0]   reg_load,
  output logic [DW-1:0]     reg_d,
  output logic              busy,
  output logic              err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREG-1:0] reg_load_q, reg_load_d;
  logic [DW-1:0]   reg_d_q, reg_d_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [PW-1:0]   pick_win;
  logic            pick_any;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  assign sel_addr = req_addr[pick_win*AW +: AW];
  assign sel_data = req_data[pick_win*DW +: DW];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    reg_d_d    = reg_d_q;
    gnt_d      = '0;
    reg_load_d = '0;
    busy_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Outputs are registered here so they appear during the WRITE cycle.
        if (pick_any) begin
          state_d = ST_WRITE;
          win_d   = pick_win;
          gnt_d   = NREQ'(onehot(8'(pick_win)));
          reg_d_d = sel_data;
          busy_d  = 1'b1;
          if ({1'b0, sel_addr} < (AW+1)'(NREG))
            reg_load_d = NREG'(onehot(8'(sel_addr)));
          else
            err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`ifdef ARB_LOCK_EN
        // Park the pointer on the winner so it takes the next arbitration.
        if (lock[win_q] && req[win_q])
          ptr_d = win_q;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      gnt_q      <= '0;
      reg_load_q <= '0;
      reg_d_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      reg_load_q <= reg_load_d;
      reg_d_q    <= reg_d_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign gnt      = gnt_q;
  assign reg_load = reg_load_q;
  assign reg_d    = reg_d_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Scoreboard bench for register_write_arbiter: requester model pushes expected grants, monitor pops and compares.
module tb_register_write_arbiter;
  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int AW   = 3;
  localparam int DW   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREG-1:0]    reg_load;
  logic [DW-1:0]      reg_d;
  logic               busy, err;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]    lock = '0;
`endif

  register_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .reg_load (reg_load),
    .reg_d    (reg_d),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External register bank driven by the DUT, and the bank the scoreboard expects.
  logic [DW-1:0] bank     [NREG] = '{default: '0};
  logic [DW-1:0] exp_bank [NREG] = '{default: '0};
  always @(posedge clk)
    for (int i = 0; i < NREG; i++)
      if (reg_load[i]) bank[i] <= reg_d;

  typedef struct {
    int            w;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Requester and arbitration reference model
  bit [NREQ-1:0] pend = '0;
  bit [NREQ-1:0] rep  = '0;
  logic [AW-1:0] a   [NREQ] = '{default: '0};
  logic [DW-1:0] dat [NREQ] = '{default: '0};
  int  mptr = 0;
  bit  m_write = 1'b0;
  int  m_w = 0;
  int  clr = -1;
  int  rate = 0;

  function automatic int pick(input bit [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic post(input int i, input int ad, input int d);
    pend[i] = 1'b1;
    a[i]    = AW'(ad);
    dat[i]  = DW'(d);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]               = pend[i];
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = dat[i];
    end
  endtask

  // Called once per cycle just after the rising edge: sets inputs for the next edge.
  task automatic step_body();
    if (clr >= 0) begin
      pend[clr] = 1'b0;
      if (rep[clr]) post(clr, $urandom_range(0, 7), $urandom);
      clr = -1;
    end
    for (int i = 0; i < NREQ; i++)
      if (!pend[i] && $urandom_range(0, 99) < rate)
        post(i, $urandom_range(0, 7), $urandom);
`ifdef ARB_LOCK_EN
    if (rate > 0) lock = NREQ'($urandom);
`endif
    drive();
    if (m_write) begin
      m_write = 1'b0;
      mptr = (m_w + 1) % NREQ;
`ifdef ARB_LOCK_EN
      if (lock[m_w] && pend[m_w]) mptr = m_w;
`endif
      clr = m_w;
    end else if (pend != '0) begin
      m_w = pick(pend, mptr);
      q.push_back('{m_w, a[m_w], dat[m_w], cyc + 1});
      m_write = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step_body();
  endtask

  // Monitor
  logic [DW-1:0] last_rd = '0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      if (gnt != '0) begin
        if (q.size() == 0) begin
          chk("unexpected gnt", gnt, 0);
        end else begin
          e = q.pop_front();
          chk("gnt", gnt, 1 << e.w);
          chk("grant cycle", cyc, e.due);
          chk("reg_load", reg_load, (int'(e.addr) < NREG) ? (1 << e.addr) : 0);
          chk("reg_d", reg_d, e.data);
          chk("busy in write", busy, 1);
          chk("err", err, (int'(e.addr) >= NREG) ? 1 : 0);
          if (int'(e.addr) < NREG) exp_bank[int'(e.addr)] = e.data;
          last_rd = e.data;
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("gnt at due cycle", gnt, 1 << q[0].w);
          void'(q.pop_front());
        end
        chk("idle reg_load", reg_load, 0);
        chk("idle busy", busy, 0);
        chk("idle err", err, 0);
        chk("idle reg_d hold", reg_d, last_rd);
      end
    end
  end

  initial begin
    int n;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset gnt", gnt, 0);
    chk("reset reg_load", reg_load, 0);
    chk("reset reg_d", reg_d, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    reset = 1'b0;
    step_body();

    // Single write to register 5
    post(2, 5, 20);
    repeat (4) tick();
    chk("bank[5] after single write", bank[5], 20);

    // Reset in the middle of a WRITE cycle
    post(1, 3, 16'hbeef);
    tick();
    chk("model committed before reset", m_write, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid-write reset gnt", gnt, 0);
    chk("mid-write reset reg_load", reg_load, 0);
    chk("mid-write reset reg_d", reg_d, 0);
    chk("mid-write reset busy", busy, 0);
    chk("mid-write reset err", err, 0);
    if (q.size() > 0) q.delete(q.size() - 1);
    m_write = 1'b0;
    mptr    = 0;
    clr     = -1;
    last_rd = '0;
    post(3, 4, 16'h3333);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step_body();
    repeat (6) tick();

    // Contention: all four requesters, requester 0 re-posts after its grant
    for (int i = 0; i < NREQ; i++) post(i, i, 16'h1000 + i);
    rep = 4'b0001;
    repeat (10) tick();
    rep = '0;
    repeat (8) tick();

    // Pointer wrap: grant 3, then 1001 goes to 0 then 3
    post(3, 3, 16'h0303);
    repeat (4) tick();
    post(0, 0, 16'h0a0a);
    post(3, 2, 16'h0b0b);
    repeat (6) tick();

    // Out-of-range addresses
    post(1, 7, 1133);
    post(2, 6, 16'h0042);
    repeat (6) tick();

`ifdef ARB_LOCK_EN
    lock = 4'b0010;
    rep  = 4'b0010;
    post(1, 1, 16'h1111);
    post(2, 2, 16'h2222);
    repeat (6) tick();
    lock = '0;
    rep  = '0;
    repeat (6) tick();
`endif

    // Random traffic
    rate = 35;
    repeat (400) tick();
    rate = 0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    n = 0;
    while ((q.size() > 0 || pend != '0 || m_write) && n < 40) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk("scoreboard drained", q.size(), 0);
    chk("requesters drained", pend, 0);
    for (int i = 0; i < NREG; i++) chk($sformatf("bank[%0d]", i), bank[i], exp_bank[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
